// File: rtl/spi_per.sv
// spi_per: SPI mode-0 peripheral with synchronized inputs, TX holding register and framing/underrun flags
module spi_per #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  tx_load_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid_out,
   output logic                  frame_err_out,
   output logic                  tx_underrun_out,
   output logic                  busy_out,
   input  logic                  chip_data_in,
   input  logic                  chip_clk_in,
   input  logic                  chip_sel_in,
   output logic                  chip_data_out,
   output logic                  chip_data_en_out
);
   localparam int CW = $clog2(DATA_WIDTH);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state;
   logic [1:0] rst_sync;
   logic rst_n;
   logic [SYNC_STAGES-1:0] copi_sync;
   logic [SYNC_STAGES:0] dclk_sync, cs_sync;
   logic [DATA_WIDTH-1:0] hold, tx_sh, src, rx_next;
   logic [DATA_WIDTH-2:0] rx_sh;
   logic [CW-1:0] cnt;
   logic fresh, fresh_w, pend;
   logic copi_s, cs_fall, cs_rise, dclk_rise, dclk_fall, last_bit;
   assign rst_n     = rst_sync[1];
   assign copi_s    = copi_sync[SYNC_STAGES-1];
   assign cs_fall   = cs_sync[SYNC_STAGES] & ~cs_sync[SYNC_STAGES-1];
   assign cs_rise   = ~cs_sync[SYNC_STAGES] & cs_sync[SYNC_STAGES-1];
   assign dclk_rise = ~dclk_sync[SYNC_STAGES] & dclk_sync[SYNC_STAGES-1];
   assign dclk_fall = dclk_sync[SYNC_STAGES] & ~dclk_sync[SYNC_STAGES-1];
   assign src       = tx_load_in ? data_in : hold;
   assign rx_next   = {rx_sh, copi_s};
   assign last_bit  = cnt == CW'(DATA_WIDTH - 1);
   // reset asserts immediately and releases on a clock edge
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_sync <= '0;
      else rst_sync <= {rst_sync[0], 1'b1};
   end
   // synchronizer chains, top bit of dclk/cs chains is the edge-detect history
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         copi_sync <= '0;
         dclk_sync <= '0;
         cs_sync   <= '0;
      end else begin
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], chip_data_in};
         dclk_sync <= {dclk_sync[SYNC_STAGES-1:0], chip_clk_in};
         cs_sync   <= {cs_sync[SYNC_STAGES-1:0], chip_sel_in};
      end
   end
   // protocol FSM; a wrap only counts as a word start once its first bit is clocked
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         data_out         <= '0;
         data_valid_out   <= 1'b0;
         frame_err_out    <= 1'b0;
         tx_underrun_out  <= 1'b0;
         busy_out         <= 1'b0;
         chip_data_out    <= 1'b0;
         chip_data_en_out <= 1'b0;
         hold             <= '0;
         tx_sh            <= '0;
         rx_sh            <= '0;
         cnt              <= '0;
         fresh            <= 1'b0;
         fresh_w          <= 1'b0;
         pend             <= 1'b0;
      end else begin
         data_valid_out  <= 1'b0;
         frame_err_out   <= 1'b0;
         tx_underrun_out <= 1'b0;
         if (tx_load_in) begin
            hold  <= data_in;
            fresh <= 1'b1;
         end
         if (state == IDLE) begin
            if (cs_fall) begin
               state            <= ACTIVE;
               busy_out         <= 1'b1;
               chip_data_en_out <= 1'b1;
               chip_data_out    <= src[DATA_WIDTH-1];
               tx_sh            <= {src[DATA_WIDTH-2:0], 1'b0};
               tx_underrun_out  <= ~(fresh | tx_load_in);
               fresh            <= 1'b0;
               cnt              <= '0;
               pend             <= 1'b0;
            end
         end else if (cs_rise) begin
            state            <= IDLE;
            busy_out         <= 1'b0;
            chip_data_en_out <= 1'b0;
            chip_data_out    <= 1'b0;
            frame_err_out    <= cnt != '0;
            cnt              <= '0;
            pend             <= 1'b0;
            if (pend) fresh <= fresh | fresh_w | tx_load_in;
         end else if (dclk_rise) begin
            rx_sh <= rx_next[DATA_WIDTH-2:0];
            if (pend) begin
               pend            <= 1'b0;
               tx_underrun_out <= ~fresh_w;
            end
            if (last_bit) begin
               cnt            <= '0;
               data_out       <= rx_next;
               data_valid_out <= 1'b1;
               tx_sh          <= src;
               pend           <= 1'b1;
               fresh_w        <= fresh | tx_load_in;
               fresh          <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (dclk_fall) begin
            chip_data_out <= tx_sh[DATA_WIDTH-1];
            tx_sh         <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end
endmodule

// File: tb/tb_spi_per.sv
// tb_spi_per: drives an SPI controller model against spi_per and checks against a word-level reference
module tb_spi_per;
   localparam int W = 8;
   logic clk_in = 1'b0;
   logic rst_n_in = 1'b0;
   logic [W-1:0] data_in = '0;
   logic tx_load_in = 1'b0;
   logic chip_data_in = 1'b0;
   logic chip_clk_in = 1'b0;
   logic chip_sel_in = 1'b1;
   logic [W-1:0] data_out;
   logic data_valid_out, frame_err_out, tx_underrun_out, busy_out, chip_data_out, chip_data_en_out;
   int ncmp = 0;
   int nfail = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int n_under = 0;
   logic [W-1:0] rx_log [256];
   logic [W-1:0] m_hold = '0;
   logic [W-1:0] m_dout = '0;
   bit m_fresh = 1'b0;
   logic [31:0] got_cipo;

   spi_per #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .tx_load_in(tx_load_in),
      .data_out(data_out), .data_valid_out(data_valid_out), .frame_err_out(frame_err_out),
      .tx_underrun_out(tx_underrun_out), .busy_out(busy_out), .chip_data_in(chip_data_in),
      .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in), .chip_data_out(chip_data_out),
      .chip_data_en_out(chip_data_en_out)
   );

   always #5 clk_in = ~clk_in;

   // pulse monitor
   always @(negedge clk_in) begin
      if (data_valid_out) begin
         rx_log[n_valid % 256] <= data_out;
         n_valid <= n_valid + 1;
      end
      if (frame_err_out) n_ferr <= n_ferr + 1;
      if (tx_underrun_out) n_under <= n_under + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [W-1:0] d);
      @(negedge clk_in);
      data_in = d;
      tx_load_in = 1'b1;
      @(negedge clk_in);
      tx_load_in = 1'b0;
      m_hold = d;
      m_fresh = 1'b1;
   endtask

   task automatic xfer(input int nbits, input logic [31:0] bits, input int hp, input bit fl,
                       input logic [W-1:0] fd, input int mid, input logic [W-1:0] md);
      int v0, f0, u0, w, eund;
      logic [31:0] ecipo;
      logic [W-1:0] src, e;
      v0 = n_valid; f0 = n_ferr; u0 = n_under; w = 0; eund = 0;
      ecipo = '0; got_cipo = '0; src = m_hold;
      for (int i = 0; i < nbits; i++) begin
         if (i == 0 && fl) begin m_hold = fd; m_fresh = 1'b1; end
         if (i % W == 0) begin
            src = m_hold;
            eund += m_fresh ? 0 : 1;
            m_fresh = 1'b0;
         end
         ecipo = {ecipo[30:0], src[W-1-(i%W)]};
         if (i == mid) begin m_hold = md; m_fresh = 1'b1; end
      end
      @(negedge clk_in);
      chip_sel_in = 1'b0;
      if (fl) begin
         repeat (2) @(negedge clk_in);
         data_in = fd;
         tx_load_in = 1'b1;
         @(negedge clk_in);
         tx_load_in = 1'b0;
         w = 3;
      end
      for (int i = 0; i < nbits; i++) begin
         chip_data_in = bits[nbits-1-i];
         repeat (hp - (i == 0 ? w : 0)) @(negedge clk_in);
         got_cipo = {got_cipo[30:0], chip_data_out};
         chip_clk_in = 1'b1;
         if (i == mid) begin
            repeat (hp / 2) @(negedge clk_in);
            data_in = md;
            tx_load_in = 1'b1;
            @(negedge clk_in);
            tx_load_in = 1'b0;
            repeat (hp - hp / 2 - 1) @(negedge clk_in);
         end else begin
            repeat (hp) @(negedge clk_in);
         end
         chip_clk_in = 1'b0;
      end
      repeat (hp) @(negedge clk_in);
      chip_sel_in = 1'b1;
      repeat (hp) @(negedge clk_in);
      check("valid_count", 32'(n_valid - v0), 32'(nbits / W));
      for (int j = 0; j < nbits / W; j++) begin
         e = W'(bits >> (nbits - (j + 1) * W));
         check("rx_word", 32'(rx_log[(v0 + j) % 256]), 32'(e));
         m_dout = e;
      end
      check("frame_err", 32'(n_ferr - f0), 32'((nbits % W) != 0));
      check("underrun", 32'(n_under - u0), 32'(eund));
      check("cipo_bits", got_cipo, ecipo);
      check("data_out", 32'(data_out), 32'(m_dout));
      check("idle_pins", 32'({busy_out, chip_data_en_out, chip_data_out}), 32'(0));
   endtask

   initial begin
      int v0, f0, u0, nb, mid, hp;
      bit fl;
      repeat (3) @(negedge clk_in);
      check("reset_outputs", 32'({data_out, data_valid_out, frame_err_out, tx_underrun_out,
                                  busy_out, chip_data_out, chip_data_en_out}), 32'(0));
      #2 rst_n_in = 1'b1;
      repeat (10) @(negedge clk_in);
      load_word(8'h3C);
      xfer(8, 32'hA5, 50, 1'b0, '0, -1, '0);
      xfer(3, 32'h5, 10, 1'b0, '0, -1, '0);
      load_word(8'h3C);
      xfer(8, 32'h9E, 10, 1'b0, '0, -1, '0);
      xfer(8, 32'h47, 10, 1'b0, '0, -1, '0);
      load_word(8'hC3);
      xfer(16, 32'h1234, 10, 1'b0, '0, 3, 8'h56);
      xfer(8, 32'h6B, 10, 1'b1, 8'h81, -1, '0);
      @(negedge clk_in);
      chip_sel_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chip_data_in = 1'($urandom_range(0, 1));
         repeat (10) @(negedge clk_in);
         chip_clk_in = 1'b1;
         repeat (10) @(negedge clk_in);
         chip_clk_in = 1'b0;
      end
      repeat (3) @(negedge clk_in);
      check("busy_mid_frame", 32'({busy_out, chip_data_en_out}), 32'(3));
      v0 = n_valid; f0 = n_ferr; u0 = n_under;
      #2 rst_n_in = 1'b0;
      #1 check("reset_abort", 32'({data_out, data_valid_out, frame_err_out, tx_underrun_out,
                                   busy_out, chip_data_out, chip_data_en_out}), 32'(0));
      @(negedge clk_in);
      repeat (3) @(negedge clk_in);
      #2 rst_n_in = 1'b1;
      repeat (20) @(negedge clk_in);
      check("cs_low_no_start", 32'(busy_out), 32'(0));
      check("no_pulses_reset", 32'((n_valid - v0) + (n_ferr - f0) + (n_under - u0)), 32'(0));
      chip_sel_in = 1'b1;
      repeat (10) @(negedge clk_in);
      m_hold = '0; m_fresh = 1'b0; m_dout = '0;
      xfer(8, 32'hFF, 10, 1'b0, '0, -1, '0);
      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 2))
            0: nb = W;
            1: nb = 2 * W;
            default: nb = $urandom_range(1, 2 * W - 1);
         endcase
         if ($urandom_range(0, 1) == 1) load_word(W'($urandom));
         fl = $urandom_range(0, 3) == 0;
         mid = -1;
         if ($urandom_range(0, 1) == 1) begin
            mid = $urandom_range(0, (nb - 1) / W) * W + $urandom_range(1, W - 2);
            if (mid >= nb) mid = -1;
         end
         hp = $urandom_range(6, 12);
         xfer(nb, $urandom, hp, fl, W'($urandom), mid, W'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/spi_per.md
SPI_PER -- requirements
Module: spi_per

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the word length in bits (>= 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops per external input (>= 2).
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock (100 MHz); all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port data_in, input, DATA_WIDTH bits: the word to return to the controller.
REQ-006 SHALL have port tx_load_in, input, 1 bit: a one-cycle strobe that captures data_in into the TX holding register.
REQ-007 SHALL have port data_out, output, DATA_WIDTH bits: the word received from the controller.
REQ-008 SHALL have port data_valid_out, output, 1 bit: a one-cycle pulse when data_out updates.
REQ-009 SHALL have port frame_err_out, output, 1 bit: a one-cycle pulse on a partial-word frame.
REQ-010 SHALL have port tx_underrun_out, output, 1 bit: a one-cycle pulse when a word starts without a fresh tx_load_in.
REQ-011 SHALL have port busy_out, output, 1 bit: high while in ACTIVE.
REQ-012 SHALL have port chip_data_in, input, 1 bit: COPI from the controller, asynchronous.
REQ-013 SHALL have port chip_clk_in, input, 1 bit: DCLK, asynchronous, idle low.
REQ-014 SHALL have port chip_sel_in, input, 1 bit: CS, asynchronous, active-low.
REQ-015 SHALL have port chip_data_out, output, 1 bit: CIPO.
REQ-016 SHALL have port chip_data_en_out, output, 1 bit: the CIPO tristate enable, high while ACTIVE.

Function
REQ-017 SHALL pass chip_data_in, chip_clk_in and chip_sel_in each through SYNC_STAGES flops, plus one history flop, for edge detection.
REQ-018 SHALL evaluate all protocol events on synchronized signals only: CS fall, CS rise, DCLK rise and DCLK fall.
REQ-019 SHALL implement the protocol as mode 0, MSB first: sample COPI on DCLK rise and change CIPO on DCLK fall.
REQ-020 SHALL use a two-state FSM: IDLE moves to ACTIVE on CS fall; ACTIVE moves to IDLE on CS rise; DCLK edges are ignored in IDLE.
REQ-021 SHALL, on CS fall, load the TX shift register from the holding register, drive CIPO with its MSB on the next cycle, and clear the bit counter.
REQ-022 SHALL, if tx_load_in is asserted in the same cycle as a word start, bypass data_in directly into the shift register and not flag underrun.
REQ-023 SHALL, on each DCLK rise in ACTIVE, shift the synchronized COPI into the RX shift register LSB and increment the bit counter.
REQ-024 SHALL, on the DATA_WIDTH-th DCLK rise, write data_out and pulse data_valid_out on the following cycle, wrap the bit counter to 0, and reload the TX shift register from the holding register.
REQ-025 SHALL, on each DCLK fall in ACTIVE, drive the next TX bit onto CIPO; a fall immediately after a word boundary drives the new word's MSB.
REQ-026 SHALL support back-to-back words under one CS, with one data_valid_out pulse per DATA_WIDTH bits.
REQ-027 SHALL pulse tx_underrun_out on each word start (CS fall or wrap) with no tx_load_in since the previous word start; the holding register then retransmits its old value.
REQ-028 SHALL, when tx_load_in arrives mid-word, update only the holding register; the current word is unaffected.
REQ-029 SHALL, on CS rise with bit counter != 0, pulse frame_err_out, leave data_out unchanged and emit no data_valid_out; with counter == 0 it SHALL be a clean end.
REQ-030 SHALL drive chip_data_out to 0 and chip_data_en_out to 0 in IDLE.
REQ-031 SHALL require a DCLK half-period >= 6 clk_in cycles, so that CIPO settles within sync latency plus 1 cycle, before the controller's next sample.
REQ-032 SHALL, if CS fall and a DCLK edge are detected in the same cycle, process CS fall only.

Reset
REQ-033 SHALL, when rst_n_in is low, immediately clear: data_out=0, data_valid_out=0, frame_err_out=0, tx_underrun_out=0, busy_out=0, chip_data_out=0, chip_data_en_out=0, holding register=0, and all shift registers, counters and synchronizers; the state SHALL be IDLE.
REQ-034 SHALL, on reset mid-frame, abort the transfer with no pulses; after release, the module SHALL wait for the next CS fall, and a CS that is already low SHALL NOT start a frame.
REQ-035 SHALL release reset synchronously to clk_in, and the bench SHALL deassert rst_n_in away from clock edges.

Verification
REQ-036 SHALL cover: tx_load 0x3C, then a controller with half-period 50 sends 0xA5 -> data_out=0xA5 with one valid pulse, the controller reads 0x3C, and no error or underrun.
REQ-037 SHALL cover: CS raised after 3 DCLK rises -> one frame_err_out pulse, data_out unchanged, and no data_valid_out.
REQ-038 SHALL cover: two frames with a single tx_load of 0x3C -> both frames return 0x3C, and tx_underrun_out pulses at the second CS fall only.
REQ-039 SHALL cover: 16 DCLKs under one CS, COPI 0x12 then 0x34, holding register reloaded with 0x56 mid-word 1 -> two valid pulses (0x12, 0x34), and the controller reads old value then 0x56.
REQ-040 SHALL cover: rst_n_in low after 4 bits of a frame -> all outputs 0 immediately, then a clean 0xFF frame is received correctly.
REQ-041 SHALL cover: tx_load_in coincident with the CS-fall detect cycle using data_in=0x81 -> the controller reads 0x81 with no underrun.
